// File: rtl/move_replay_buffer_pkg.sv
// Shared definitions for the move replay buffer: move codes and FSM states.
package move_replay_buffer_pkg;

  // Move codes as written by the producer and replayed to the consumer.
  localparam logic [1:0] MV_XM = 2'b00;  // X - 1
  localparam logic [1:0] MV_YP = 2'b01;  // Y + 1
  localparam logic [1:0] MV_YM = 2'b10;  // Y - 1
  localparam logic [1:0] MV_XP = 2'b11;  // X + 1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/move_fifo.sv
// DEPTH x 2 show-ahead FIFO holding move codes. Pointers wrap modulo DEPTH;
// the storage array itself is never reset.
module move_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [1:0]               wr_data,
  input  logic                     rd_en,
  output logic [1:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == (AW+1)'(0));
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_wr   = wr_en && !full && !clr;
  assign do_rd   = rd_en && !empty && !clr;

  // Next-state for pointers and occupancy; clr restarts an empty buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = (AW+1)'(0);
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/move_replay_buffer.sv
// Records a path of moves, then replays them in order while tracking the
// (x,y) position reached before each presented move.
module move_replay_buffer
  import move_replay_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   wr_en,
  input  logic [1:0]             wr_dir,
  input  logic                   wr_last,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [1:0]             out_dir,
  output logic [CW-1:0]          out_x,
  output logic [CW-1:0]          out_y,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   done
);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [1:0]    last_dir_q, last_dir_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          fifo_clr;
  logic          fifo_wr;
  logic          handshake;
  logic [1:0]    head_dir;

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (fifo_clr),
    .wr_en   (fifo_wr),
    .wr_data (wr_dir),
    .rd_en   (handshake),
    .rd_data (head_dir),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = (state_q == ST_DRAIN) && !empty;
  assign handshake = out_valid && out_ready;
  // Between handshakes out_dir shows the head; otherwise it keeps the last move consumed.
  assign out_dir   = out_valid ? head_dir : last_dir_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

  // FSM next state, write gating, overflow flag and position tracking.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    last_dir_d = last_dir_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    fifo_clr   = 1'b0;
    fifo_wr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          fifo_clr   = 1'b1;
          x_d        = CW'(0);
          y_d        = CW'(0);
          last_dir_d = MV_XM;
          overflow_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            fifo_wr = 1'b1;
          end
          if (wr_last) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          last_dir_d = head_dir;
          // Position arithmetic wraps naturally at CW bits.
          case (head_dir)
            MV_XM:   x_d = x_q - CW'(1);
            MV_YP:   y_d = y_q + CW'(1);
            MV_YM:   y_d = y_q - CW'(1);
            MV_XP:   x_d = x_q + CW'(1);
            default: x_d = x_q;
          endcase
        end else if (empty) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, position and flag registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= CW'(0);
      y_q        <= CW'(0);
      last_dir_q <= MV_XM;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      last_dir_q <= last_dir_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

endmodule
